// File: rtl/dmux_pkg.sv
// rtl/dmux_pkg.sv - shared constants and FSM state type for the demux dispatch controller
package dmux_pkg;
  localparam int N_OUT = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first set mask bit after ptr, modulo N_OUT
module rr_pick
  import dmux_pkg::*;
(
  input  logic [N_OUT-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |mask;
    for (int i = N_OUT; i >= 1; i--) begin
      idx = ptr + SEL_W'(i);
      if (mask[idx]) begin
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/dmux_dispatch_ctrl.sv
// rtl/dmux_dispatch_ctrl.sv - round-robin burst dispatcher driving the 1-to-8 demux select
module dmux_dispatch_ctrl
  import dmux_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [N_OUT-1:0] ch_mask,
  input  logic [N_OUT-1:0] out_ready,
  output logic [N_OUT-1:0] out_valid,
  output logic [DW-1:0]    out_data,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [SEL_W-1:0] grant;
  logic             grant_any;
  logic             ch_ok;
  logic             hs;

  rr_pick u_rr_pick (
    .mask  (ch_mask),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (grant_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= SEL_W'(N_OUT - 1);
      sel_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    beat_cnt_d = beat_cnt_q;
    in_ready   = 1'b0;
    out_valid  = '0;
    ch_ok      = ch_mask[sel_q];
    hs         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && (|ch_mask)) begin
          state_d = ARB;
        end
      end

      ARB: begin
        if (grant_any) begin
          sel_d      = grant;
          ptr_d      = grant;
          beat_cnt_d = '0;
          state_d    = XFER;
        end else begin
          state_d = IDLE;
        end
      end

      XFER: begin
        // Clearing the granted channel's enable blocks the beat in the same cycle.
        out_valid[sel_q] = in_valid & ch_ok;
        in_ready         = out_ready[sel_q] & ch_ok;
        hs               = in_valid & in_ready;
        if (!ch_ok) begin
          beat_cnt_d = '0;
          state_d    = ARB;
        end else if (hs) begin
          if (beat_cnt_q != CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (in_last || (beat_cnt_q == LAST_BEAT)) begin
            state_d = ARB;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_data = in_data;
  assign sel      = sel_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmux_dispatch_ctrl.sv
// tb/tb_dmux_dispatch_ctrl.sv - scoreboard bench for the round-robin demux dispatcher
module tb_dmux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] ch_mask;
  logic [7:0] out_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];

  dmux_dispatch_ctrl #(.DW(8), .BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .ch_mask   (ch_mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on every handshake.
  initial begin
    logic [10:0] e;
    logic [7:0]  onehot;
    forever begin
      @(negedge clk);
      #2;
      onehot = 8'd1 << sel;
      if ((out_valid & ~onehot) != 8'd0) check("out_valid_off_sel", out_valid, out_valid & onehot);
      if ((out_valid & ~ch_mask) != 8'd0) check("out_valid_masked", out_valid, out_valid & ch_mask);
      if (in_valid && in_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_data, -1);
        end else begin
          e = exp_q.pop_front();
          check("beat_channel", sel, e[10:8]);
          check("beat_out_valid", out_valid, 8'd1 << e[10:8]);
          check("beat_data", out_data, e[7:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit last, input int ch, input int exp_wait);
    int waits;
    bit got;
    logic [2:0] c;
    c = ch[2:0];
    exp_q.push_back({c, d});
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waits    = 0;
    got      = 1'b0;
    while (!got && waits < 50) begin
      #1;
      got = in_ready;
      waits++;
      @(negedge clk);
    end
    if (!got) check("handshake_timeout", waits, -1);
    else if (exp_wait != 0) check("handshake_latency", waits, exp_wait);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] mask);
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    ch_mask   = mask;
    out_ready = 8'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    ch_mask   = 8'hFF;
    out_ready = 8'hFF;

    // Reset state.
    do_reset(8'hFF);
    #1;
    check("reset_busy", busy, 0);
    check("reset_sel", sel, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    @(negedge clk);

    // 32 beats, all channels: 0..7 in order, 4 beats each, one ARB gap.
    for (int i = 0; i < 32; i++) begin
      send(8'(i), 1'b0, i / 4, (i == 0) ? 3 : ((i % 4) == 0 ? 2 : 1));
    end

    // Two enabled channels alternate 2,7,2,7.
    do_reset(8'b1000_0100);
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h40 + i), 1'b0, ((i / 4) % 2 == 0) ? 2 : 7, (i == 0) ? 3 : ((i % 4) == 0 ? 2 : 1));
    end

    // in_last on 2nd beat of channel 0 ends the burst early.
    do_reset(8'hFF);
    send(8'h30, 1'b0, 0, 3);
    send(8'h31, 1'b1, 0, 1);
    for (int i = 0; i < 4; i++) send(8'(8'h32 + i), 1'b0, 1, (i == 0) ? 2 : 1);

    // Stall channel 3 for 10 cycles, then finish its 4-beat burst.
    do_reset(8'hFF);
    send(8'h50, 1'b1, 0, 3);
    send(8'h51, 1'b1, 1, 2);
    send(8'h52, 1'b1, 2, 2);
    send(8'h53, 1'b0, 3, 2);
    out_ready = 8'hF7;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    repeat (10) begin
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_sel", sel, 3);
      @(negedge clk);
    end
    out_ready = 8'hFF;
    send(8'h54, 1'b0, 3, 1);
    send(8'h55, 1'b0, 3, 1);
    send(8'h56, 1'b0, 3, 1);
    send(8'h57, 1'b1, 4, 2);

    // Clearing ch_mask[5] mid-burst aborts; next grant is 6.
    do_reset(8'hFF);
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b1, i, (i == 0) ? 3 : 2);
    send(8'h65, 1'b0, 5, 2);
    ch_mask  = 8'hDF;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clk);
    send(8'h66, 1'b0, 6, 2);

    // One-cycle reset mid-burst on channel 4 restarts at channel 0.
    do_reset(8'hFF);
    for (int i = 0; i < 4; i++) send(8'(8'h70 + i), 1'b1, i, (i == 0) ? 3 : 2);
    send(8'h74, 1'b0, 4, 2);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_sel", sel, 0);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 0);
    @(negedge clk);
    send(8'h75, 1'b0, 0, 3);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmux_dispatch_ctrl.md
# dmux_dispatch_ctrl

Round-robin dispatch controller for the 1-to-8 demultiplexer datapath. It accepts one valid/ready input stream and selects a destination channel among eight. It drives the demux select and forwards bursts of up to BURST beats to that channel, then rotates to the next enabled channel. It sits between a single producer and eight consumers and owns the demux `sel` field.

## Interface
- `N_OUT`, 8: number of destination channels (fixed at 8 for this release).
- `SEL_W`, 3: select width, equal to clog2(N_OUT).
- `DW`, 8: data width.
- `BURST`, 4: maximum beats per grant; legal range 1..255.

- `clk`: input, 1. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1. Reset is synchronous and active-low.
- `in_valid`: input, 1. Producer has a beat.
- `in_data`: input, DW. Producer beat payload.
- `in_last`: input, 1. Marks the final beat of a packet; ends the burst early.
- `in_ready`: output, 1. Beat accepted when `in_valid & in_ready`.
- `ch_mask`: input, N_OUT. Per-channel enable; a bit at 0 excludes that channel from arbitration.
- `out_ready`: input, N_OUT. Per-channel consumer ready.
- `out_valid`: output, N_OUT. One-hot or zero; bit `sel` only.
- `out_data`: output, DW. Equals `in_data` (broadcast; consumers qualify with `out_valid`).
- `sel`: output, SEL_W. Registered demux select.
- `busy`: output, 1. High in ARB or XFER.

## Operation
- FSM states: IDLE, ARB, XFER.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - Go to ARB when `in_valid & |ch_mask`.
- **ARB** (one cycle)
  - Grant = first set bit of `ch_mask` searching from `ptr+1` upward, modulo 8.
  - Register `sel`=grant, `ptr`=grant, `beat_cnt`=0.
  - Go to XFER.
  - If `ch_mask`==0 in this cycle: go to IDLE; `sel` and `ptr` are unchanged.
- **XFER** (combinational pass-through)
  - `out_valid[sel] = in_valid & ch_mask[sel]`.
  - `in_ready = out_ready[sel] & ch_mask[sel]`.
  - Each handshake increments `beat_cnt` (8-bit, saturating, never wraps).
- **Exit from XFER to ARB**, on any of:
  - A handshake with `in_last`=1.
  - A handshake with `beat_cnt`==BURST-1.
  - `ch_mask[sel]`==0 (abort): no beat is transferred that cycle and `beat_cnt` clears.
- If both `in_last` and the BURST limit occur on the same handshake, there is a single exit; no special case.
- Stall inside XFER: while `out_ready[sel]`=0, the controller stays on that channel indefinitely. There is no skip and no timeout; `in_valid` low also holds XFER.
- Round-robin pointer wraps from 7 to 0; with a single enabled channel, the same channel is re-granted.
- `out_data` is always `in_data`; there is no storage in the data path.

## Timing
- Reset (`rst_n`=0 at a rising edge) applies the following values, including mid-burst; any in-flight beat is dropped from the controller's view:
  - state=IDLE.
  - `ptr`=7, so the first grant is channel 0.
  - `sel`=0.
  - `beat_cnt`=0.
  - `in_ready`=0.
  - `out_valid`=0.
  - `busy`=0.
- First beat: `in_valid` rises in IDLE at cycle t; ARB at t+1; earliest handshake at t+2.
- Back-to-back bursts: one dead cycle (ARB) between the last beat of one grant and the first beat of the next.
- `ch_mask` changes take effect in the next ARB, except that clearing `ch_mask[sel]` in XFER aborts combinationally in that same cycle.
- `sel` changes only on the ARB→XFER edge; it is stable throughout XFER.

## Structure
- `dmux_pkg` holds:
  - `N_OUT`, `SEL_W` constants.
  - The state enum `{IDLE, ARB, XFER}`.
  - The `beat_cnt` width constant (8).
- One sub-module, `rr_pick`: a combinational rotating priority encoder.
  - Inputs: `mask[N_OUT]`, `ptr[SEL_W]`.
  - Outputs: `grant[SEL_W]`, `any`.
  - Verified standalone.
- Top-level contents: FSM, `ptr`/`sel`/`beat_cnt` registers, pass-through gating. Target 150–250 lines.

## Test plan
- Reset then stream, `ch_mask`=8'hFF, all `out_ready`=1, BURST=4, 32 beats with no `in_last` → grants to channels 0,1,2,...,7 in order, 4 beats each, one ARB gap between grants.
- `ch_mask`=8'b1000_0100 → grants alternate 2, 7, 2, 7; channels 0,1,3–6 never see `out_valid`.
- `in_last`=1 on the 2nd beat of the channel-0 burst → exit after 2 beats; next grant is channel 1.
- `out_ready[3]`=0 for 10 cycles during the channel-3 grant → `in_ready`=0 and `sel`=3 held for all 10 cycles; burst then completes with 4 beats.
- Clear `ch_mask[5]` mid-burst on channel 5 → `out_valid`=0 and `in_ready`=0 that cycle; next grant is channel 6.
- Assert `rst_n`=0 for one cycle mid-burst on channel 4 → next cycle state=IDLE, `sel`=0, `out_valid`=0; the following grant is channel 0.
